// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: loads the reset vector, fetches 16-bit words,
// merges two-word instructions with their immediate. Optional FETCH_REDIRECT_EN adds branch redirect.
module fetch_unit #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RST_LO_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            stall,
    output logic [6:0]      opcode,
    output logic [2:0]      rdst,
    output logic [2:0]      rsrc1,
    output logic [2:0]      rsrc2,
    output logic [15:0]     imm,
    output logic [PC_W-1:0] pc_out,
    output logic            instr_valid,
    output logic            halted,
    input  logic            redir_en,
    input  logic [PC_W-1:0] redir_pc
);

    typedef enum logic [2:0] {
        RST_LO = 3'd0,
        RST_HI = 3'd1,
        FETCH  = 3'd2,
        IMM    = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [6:0] OP_IADD = 7'b0100000;
    localparam logic [6:0] OP_LDM  = 7'b0110101;
    localparam logic [6:0] OP_LDD  = 7'b0100010;
    localparam logic [6:0] OP_STD  = 7'b0100011;
    localparam logic [6:0] OP_HLT  = 7'b1100001;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     vec_lo_q, vec_lo_d;
    logic [15:0]     hold_q, hold_d;
    logic [PC_W-1:0] hold_pc_q, hold_pc_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      rdst_q, rdst_d;
    logic [2:0]      rsrc1_q, rsrc1_d;
    logic [2:0]      rsrc2_q, rsrc2_d;
    logic [15:0]     imm_q, imm_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic            instr_valid_q, instr_valid_d;

    logic [6:0]      word_op;
    logic            two_word;
    logic            redirect;
    logic [PC_W-1:0] pc_inc;

    assign word_op = imem_rdata[15:9];
    assign pc_inc  = pc_q + PC_W'(1);

    always_comb begin
        two_word = 1'b0;
        case (word_op)
            OP_IADD, OP_LDM, OP_LDD, OP_STD: two_word = 1'b1;
            default:                         two_word = 1'b0;
        endcase
    end

`ifdef FETCH_REDIRECT_EN
    assign redirect = redir_en && ((state_q == FETCH) || (state_q == IMM));
`else
    logic unused_redir;
    assign unused_redir = ^{redir_en, redir_pc};
    assign redirect     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        vec_lo_d      = vec_lo_q;
        hold_d        = hold_q;
        hold_pc_d     = hold_pc_q;
        opcode_d      = opcode_q;
        rdst_d        = rdst_q;
        rsrc1_d       = rsrc1_q;
        rsrc2_d       = rsrc2_q;
        imm_d         = imm_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        imem_addr     = pc_q;

        if (redirect) begin
            // Redirect wins over stall and drops any half-fetched instruction.
            pc_d          = redir_pc;
            state_d       = FETCH;
            instr_valid_d = 1'b0;
        end else begin
            case (state_q)
                RST_LO: begin
                    imem_addr     = RST_LO_ADDR;
                    vec_lo_d      = imem_rdata;
                    instr_valid_d = 1'b0;
                    state_d       = RST_HI;
                end
                RST_HI: begin
                    imem_addr     = RST_LO_ADDR + PC_W'(1);
                    pc_d          = PC_W'({imem_rdata, vec_lo_q});
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
                FETCH: begin
                    if (!stall) begin
                        pc_d = pc_inc;
                        if (two_word) begin
                            hold_d        = imem_rdata;
                            hold_pc_d     = pc_q;
                            instr_valid_d = 1'b0;
                            state_d       = IMM;
                        end else begin
                            opcode_d      = word_op;
                            rdst_d        = imem_rdata[8:6];
                            rsrc1_d       = imem_rdata[5:3];
                            rsrc2_d       = imem_rdata[2:0];
                            imm_d         = 16'h0000;
                            pc_out_d      = pc_q;
                            instr_valid_d = 1'b1;
                            state_d       = (word_op == OP_HLT) ? HALT : FETCH;
                        end
                    end
                end
                IMM: begin
                    if (!stall) begin
                        opcode_d      = hold_q[15:9];
                        rdst_d        = hold_q[8:6];
                        rsrc1_d       = hold_q[5:3];
                        rsrc2_d       = hold_q[2:0];
                        imm_d         = imem_rdata;
                        pc_out_d      = hold_pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_inc;
                        state_d       = FETCH;
                    end
                end
                HALT: begin
                    instr_valid_d = 1'b0;
                end
                default: begin
                    state_d       = RST_LO;
                    instr_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RST_LO;
            pc_q          <= '0;
            vec_lo_q      <= '0;
            hold_q        <= '0;
            hold_pc_q     <= '0;
            opcode_q      <= '0;
            rdst_q        <= '0;
            rsrc1_q       <= '0;
            rsrc2_q       <= '0;
            imm_q         <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            vec_lo_q      <= vec_lo_d;
            hold_q        <= hold_d;
            hold_pc_q     <= hold_pc_d;
            opcode_q      <= opcode_d;
            rdst_q        <= rdst_d;
            rsrc1_q       <= rsrc1_d;
            rsrc2_q       <= rsrc2_d;
            imm_q         <= imm_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign opcode      = opcode_q;
    assign rdst        = rdst_q;
    assign rsrc1       = rsrc1_q;
    assign rsrc2       = rsrc2_q;
    assign imm         = imm_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs push expected issues,
// a negedge monitor pops and compares each newly issued instruction.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall = 1'b0;
    logic [6:0]  opcode;
    logic [2:0]  rdst, rsrc1, rsrc2;
    logic [15:0] imm;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        halted;
    logic        redir_en = 1'b0;
    logic [31:0] redir_pc = 32'h0;

    logic [15:0] mem [256];
    logic [15:0] top_word = 16'h0000;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  rd;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [15:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic stall_at_edge = 1'b0;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .opcode     (opcode),
        .rdst       (rdst),
        .rsrc1      (rsrc1),
        .rsrc2      (rsrc2),
        .imm        (imm),
        .pc_out     (pc_out),
        .instr_valid(instr_valid),
        .halted     (halted),
        .redir_en   (redir_en),
        .redir_pc   (redir_pc)
    );

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr == 32'hFFFF_FFFF) ? top_word :
                        (imem_addr < 32'd256)        ? mem[imem_addr[7:0]] : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic [2:0] rd, input logic [2:0] r1,
                        input logic [2:0] r2, input logic [15:0] im, input logic [31:0] pc);
        exp_t e;
        e.op = op; e.rd = rd; e.r1 = r1; e.r2 = r2; e.imm = im; e.pc = pc;
        exp_q.push_back(e);
    endtask

    // A held (stalled) instruction stays valid but is not a new issue.
    always @(posedge clk) stall_at_edge <= stall;

    always @(negedge clk) begin
        if (instr_valid && !stall_at_edge) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue_pc", pc_out, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("issue_opcode", {25'd0, opcode}, {25'd0, e.op});
                chk("issue_rdst",   {29'd0, rdst},   {29'd0, e.rd});
                chk("issue_rsrc1",  {29'd0, rsrc1},  {29'd0, e.r1});
                chk("issue_rsrc2",  {29'd0, rsrc2},  {29'd0, e.r2});
                chk("issue_imm",    {16'd0, imm},    {16'd0, e.imm});
                chk("issue_pc_out", pc_out,          e.pc);
            end
        end
    end

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 16'h0000;
        top_word = 16'h0000;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        stall    = 1'b0;
        redir_en = 1'b0;
        @(negedge clk);
        chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted},      32'd0);
        chk("rst_opcode", {25'd0, opcode},      32'd0);
        chk("rst_imm",    {16'd0, imm},         32'd0);
        chk("rst_pc_out", pc_out,               32'd0);
        chk("rst_addr",   imem_addr,            32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
        @(negedge clk);
        chk("halt_valid_low", {31'd0, instr_valid}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Program A: reset vector, single-word stream, HLT hold
        clear_mem();
        mem[0] = 16'h0010; mem[1] = 16'h0000;
        mem[8'h10] = 16'h0253;
        mem[8'h11] = 16'h132E;
        mem[8'h12] = 16'h1BC1;
        mem[8'h13] = 16'hC200;
        push(7'b0000001, 3'd1, 3'd2, 3'd3, 16'h0, 32'h10);
        push(7'b0001001, 3'd4, 3'd5, 3'd6, 16'h0, 32'h11);
        push(7'b0001101, 3'd7, 3'd0, 3'd1, 16'h0, 32'h12);
        push(7'b1100001, 3'd0, 3'd0, 3'd0, 16'h0, 32'h13);
        apply_reset();
        @(negedge clk);
        chk("a_rsthi_addr", imem_addr, 32'd1);
        @(negedge clk);
        chk("a_first_addr", imem_addr, 32'h10);
        chk("a_first_valid_low", {31'd0, instr_valid}, 32'd0);
        wait_halt();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("a_halt_hold_valid", {31'd0, instr_valid}, 32'd0);
            chk("a_halt_hold_halted", {31'd0, halted}, 32'd1);
        end

        // Program B: two-word LDM, IADD stalled in IMM, HLT
        clear_mem();
        mem[0] = 16'h0010; mem[1] = 16'h0000;
        mem[8'h10] = 16'h6A80;
        mem[8'h11] = 16'hBEEF;
        mem[8'h12] = 16'h40E0;
        mem[8'h13] = 16'h1234;
        mem[8'h14] = 16'hC200;
        push(7'b0110101, 3'd2, 3'd0, 3'd0, 16'hBEEF, 32'h10);
        push(7'b0100000, 3'd3, 3'd4, 3'd0, 16'h1234, 32'h12);
        push(7'b1100001, 3'd0, 3'd0, 3'd0, 16'h0,    32'h14);
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("b_bubble_valid", {31'd0, instr_valid}, 32'd0);
        chk("b_imm_addr", imem_addr, 32'h11);
        @(negedge clk);
        chk("b_next_addr", imem_addr, 32'h12);
        @(negedge clk);
        chk("b_iadd_bubble", {31'd0, instr_valid}, 32'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_stall_valid", {31'd0, instr_valid}, 32'd0);
            chk("b_stall_addr", imem_addr, 32'h13);
            chk("b_stall_pc_out", pc_out, 32'h10);
        end
        stall = 1'b0;
        wait_halt();

        // Program C: redirect with stall during IMM
        clear_mem();
        mem[0] = 16'h0010; mem[1] = 16'h0000;
        mem[8'h10] = 16'h40E0;
        mem[8'h11] = 16'h1234;
        mem[8'h12] = 16'h0253;
        mem[8'h13] = 16'hC200;
        mem[8'h40] = 16'h132E;
        mem[8'h41] = 16'hC200;
`ifdef FETCH_REDIRECT_EN
        push(7'b0001001, 3'd4, 3'd5, 3'd6, 16'h0, 32'h40);
        push(7'b1100001, 3'd0, 3'd0, 3'd0, 16'h0, 32'h41);
`else
        push(7'b0100000, 3'd3, 3'd4, 3'd0, 16'h1234, 32'h10);
        push(7'b0000001, 3'd1, 3'd2, 3'd3, 16'h0,    32'h12);
        push(7'b1100001, 3'd0, 3'd0, 3'd0, 16'h0,    32'h13);
`endif
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        stall    = 1'b1;
        redir_en = 1'b1;
        redir_pc = 32'h40;
        @(negedge clk);
        chk("c_redir_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_REDIRECT_EN
        chk("c_redir_addr", imem_addr, 32'h40);
`else
        chk("c_redir_addr", imem_addr, 32'h11);
`endif
        stall    = 1'b0;
        redir_en = 1'b0;
        wait_halt();

        // Program D: PC wraps between opcode word and its immediate
        clear_mem();
        mem[0] = 16'hFFFF; mem[1] = 16'hFFFF; mem[2] = 16'hC200;
        top_word = 16'h6A80;
        push(7'b0110101, 3'd2, 3'd0, 3'd0, 16'hFFFF, 32'hFFFF_FFFF);
        push(7'b1111111, 3'd7, 3'd7, 3'd7, 16'h0,    32'h1);
        push(7'b1100001, 3'd0, 3'd0, 3'd0, 16'h0,    32'h2);
        apply_reset();
        @(negedge clk);
        @(negedge clk);
        chk("d_top_addr", imem_addr, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("d_wrap_addr", imem_addr, 32'h0);
        wait_halt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch/issue stage: the producer end of the opcode interface that feeds the control unit.
- Reads 16-bit words from the instruction memory, splits each instruction word into opcode and register fields, and merges two-word instructions (IADD, LDM, LDD, STD) with their 16-bit immediate.
- Presents one registered instruction per cycle with a valid flag.
- Owns the PC: reset-vector load, HLT freeze, decode-stage stall, and (optionally) branch redirect.

## Interface
Parameters:
- PC_W, 32, PC and instruction-address width
- RST_LO_ADDR, 0, address of reset-vector low half (high half at RST_LO_ADDR+1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- imem_addr  out  PC_W  word address to instruction memory (combinational from state/PC)
- imem_rdata  in  16  instruction memory word; asynchronous read, valid same cycle as imem_addr
- stall  in  1  decode cannot accept; hold everything
- opcode  out  7  registered instr[15:9], goes to control unit
- rdst, rsrc1, rsrc2  out  3 each  registered instr[8:6], [5:3], [2:0]
- imm  out  16  registered immediate; 0 for single-word instructions
- pc_out  out  PC_W  address of the first word of the issued instruction
- instr_valid  out  1  opcode/fields/imm/pc_out describe a real instruction this cycle
- halted  out  1  high while in HALT
- redir_en  in  1  redirect request (only with FETCH_REDIRECT_EN)
- redir_pc  in  PC_W  redirect target (only with FETCH_REDIRECT_EN)

## Operation
States:
- RST_LO: imem_addr=RST_LO_ADDR, capture low half of the vector; next RST_HI.
- RST_HI: imem_addr=RST_LO_ADDR+1; pc <= {upper bits zero, rdata, lo} truncated/extended to PC_W; next FETCH.
- FETCH: imem_addr=pc; decode opcode=rdata[15:9].
  - Two-word opcode (0100000 IADD, 0110101 LDM, 0100010 LDD, 0100011 STD): latch word into hold reg, pc<=pc+1, instr_valid<=0, next IMM.
  - HLT (1100001): issue it (instr_valid<=1), pc<=pc+1, next HALT.
  - Any other opcode, including undefined ones: issue as single-word, imm<=0, pc<=pc+1.
- IMM: imem_addr=pc; issue held word with imm<=rdata, pc_out<=address of held word, instr_valid<=1, pc<=pc+1; next FETCH.
- HALT: instr_valid=0, halted=1, pc frozen; only reset leaves HALT.

Reset values:
- state=RST_LO, pc=0, opcode=0, fields=0, imm=0, pc_out=0, instr_valid=0, halted=0.

Rules:
- stall=1 in FETCH/IMM: state, pc, hold reg and all outputs unchanged (instr_valid keeps its value). stall is ignored in RST_LO, RST_HI and HALT.
- PC arithmetic is modulo 2^PC_W; pc=all-ones wraps to 0, including between an opcode word and its immediate.
- Reset asserted in any state (mid-IMM, HALT, during stall) returns to RST_LO the next edge; partial instruction discarded.

## Timing
- Reset released before edge 1: edge 1 captures low vector, edge 2 loads pc, edge 3 presents the first instruction.
- Single-word instruction: issued 1 edge after its address is driven; throughput 1 per cycle.
- Two-word instruction: 2 edges; a bubble (instr_valid=0) in the first cycle.
- HLT: issued on the edge that enters HALT; instr_valid=0 from the following edge on.

## Configuration
- FETCH_REDIRECT_EN defined:
  - redir_en=1 in FETCH or IMM: pc<=redir_pc, state<=FETCH, instr_valid<=0, any held word dropped.
  - Redirect beats stall.
  - Ignored in RST_LO, RST_HI and HALT.
- FETCH_REDIRECT_EN undefined: redir_en/redir_pc are unused and have no effect; there is no redirect logic.

## Test plan
- Reset vector: M[0]=0x0010, M[1]=0x0000, reset 2 cycles then release -> edge 3: pc_out=0x10, instr_valid=1, opcode=M[0x10][15:9].
- Single-word stream: M[0x10..0x12]=ADD, SUB, AND -> three consecutive valid cycles with opcodes 0000001, 0001001, 0001101 and pc_out 0x10, 0x11, 0x12.
- Two-word: M[0x10]=LDM (0110101, rdst=2), M[0x11]=0xBEEF -> one cycle instr_valid=0, then opcode=0110101, rdst=2, imm=0xBEEF, pc_out=0x10; next instruction fetched from 0x12.
- Stall: assert stall 3 cycles while an IADD is in IMM -> outputs frozen, pc unchanged; after release the IADD issues once, never duplicated.
- HLT: M[0x13]=HLT -> HLT issued once, then halted=1, instr_valid=0 for 20 cycles; reset then restarts from the vector.
- Redirect (FETCH_REDIRECT_EN): redir_en=1, redir_pc=0x40 with stall=1 during IMM -> held word dropped; next valid pc_out=0x40. Without the macro the same stimulus is ignored.
